// File: rtl/bl_wl_prog_ctrl.sv
// Row-at-a-time BL/WL programming sequencer for a ROWS x COLS configuration SRAM bank; optional bank clear via PROG_BANK_CLEAR_EN.
// Latency: 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC cycles per row, plus CLR_CYC (when PROG_BANK_CLEAR_EN is defined) and 1 DONE cycle per program.
// Backpressure: din_ready is high only in WAIT_DATA; the block stalls indefinitely there with wl low until din_valid arrives.
module bl_wl_prog_ctrl #(
  parameter int ROWS      = 16,
  parameter int COLS      = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CLR_CYC   = 2
) (
  input  logic                    prog_clk,
  input  logic                    RSTN,
  input  logic                    start,
  input  logic                    abort,
  input  logic [COLS-1:0]         din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [COLS-1:0]         bl,
  output logic [ROWS-1:0]         wl,
  output logic                    cell_reset,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(ROWS)-1:0] row_idx
);

  localparam int RW    = $clog2(ROWS);
  // The counter is sized over every timed window, CLR_CYC included, so the
  // width does not change between the clear-enabled and clear-less builds.
  localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE,
`ifdef PROG_BANK_CLEAR_EN
    CLEAR,
`endif
    WAIT_DATA,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [RW-1:0]   row_nxt;
  logic [COLS-1:0] bl_nxt;

  // State, phase counter, row index and bit-line register.
  always_ff @(posedge prog_clk) begin
    if (!RSTN) begin
      state   <= IDLE;
      cnt     <= '0;
      row_idx <= '0;
      bl      <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      row_idx <= row_nxt;
      bl      <= bl_nxt;
    end
  end

  // Next-state logic; each timed state loads N-1 on entry and exits at zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row_idx;
    bl_nxt    = bl;
    case (state)
      IDLE: begin
        row_nxt = '0;
        if (start) begin
`ifdef PROG_BANK_CLEAR_EN
          state_nxt = CLEAR;
          cnt_nxt   = CW'(CLR_CYC - 1);
`else
          state_nxt = WAIT_DATA;
`endif
        end
      end
`ifdef PROG_BANK_CLEAR_EN
      CLEAR: begin
        if (cnt == '0) state_nxt = WAIT_DATA;
        else           cnt_nxt   = cnt - CW'(1);
      end
`endif
      WAIT_DATA: begin
        if (din_valid) begin
          bl_nxt    = din;
          state_nxt = SETUP;
          cnt_nxt   = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = CW'(PULSE_CYC - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          // The last row goes to DONE without touching row_idx, so it never wraps.
          if (row_idx == RW'(ROWS - 1)) begin
            state_nxt = DONE;
          end else begin
            row_nxt   = row_idx + RW'(1);
            state_nxt = WAIT_DATA;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        bl_nxt    = '0;
        row_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort dominates everything but reset; a start in the same cycle is lost.
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      row_nxt   = '0;
      bl_nxt    = '0;
    end
  end

  // Outputs decoded purely from registered state: no input reaches an output combinationally.
  always_comb begin
    wl = '0;
    if (state == PULSE) wl[row_idx] = 1'b1;
    busy      = (state != IDLE);
    din_ready = (state == WAIT_DATA);
    done      = (state == DONE);
`ifdef PROG_BANK_CLEAR_EN
    cell_reset = (state == CLEAR);
`else
    cell_reset = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bl_wl_prog_ctrl.sv
// Bench for bl_wl_prog_ctrl: random row data and valid gaps against a timing-arithmetic reference model.
// Latency: model predicts every output on every cycle from transfer times and the window lengths.
// Backpressure: din_valid gaps and stalls are driven from the bench; din_ready is predicted by the model.
module tb_bl_wl_prog_ctrl;
  localparam int ROWS = 16;
  localparam int COLS = 8;
  localparam int S    = 1;
  localparam int P    = 2;
  localparam int H    = 1;
`ifdef PROG_BANK_CLEAR_EN
  localparam int CLRC = 2;
`else
  localparam int CLRC = 0;
`endif
  localparam int RP   = 1 + S + P + H;

  logic            prog_clk = 1'b0;
  logic            RSTN = 1'b0, start = 1'b0, abort = 1'b0, din_valid = 1'b0;
  logic [COLS-1:0] din = '0;
  logic            din_ready, cell_reset, busy, done;
  logic [COLS-1:0] bl;
  logic [ROWS-1:0] wl;
  logic [3:0]      row_idx;

  bl_wl_prog_ctrl #(.ROWS(ROWS), .COLS(COLS), .SETUP_CYC(S), .PULSE_CYC(P),
                    .HOLD_CYC(H), .CLR_CYC(2)) dut (
    .prog_clk(prog_clk), .RSTN(RSTN), .start(start), .abort(abort),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .bl(bl), .wl(wl),
    .cell_reset(cell_reset), .busy(busy), .done(done), .row_idx(row_idx));

  always #5 prog_clk = ~prog_clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  // Reference model state and DUT observations for the current program.
  int       cyc = 0;
  bit       mon_en = 0, killed = 0, prev_busy = 0;
  bit       m_live = 0, m_cur = 0;
  int       m_e0 = 0, m_t = 0, m_row = 0;
  logic [COLS-1:0] m_data = '0;
  int       start_cyc = 0, done_cnt = 0, done_cyc = 0, idle_cyc = 0;
  int       first_rdy = -1, cr_cnt = 0, xfer_cnt = 0;
  int       wl_cnt[ROWS];

  always @(posedge prog_clk) cyc <= cyc + 1;

  always @(negedge prog_clk) begin : model
    logic            e_busy, e_done, e_rdy, e_cr;
    logic [3:0]      e_row;
    logic [ROWS-1:0] e_wl;
    logic [COLS-1:0] e_bl;
    int              d;
    if (mon_en) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_busy && !busy) idle_cyc = cyc;
      prev_busy = busy;
      if (cell_reset) cr_cnt++;
      if (din_ready && first_rdy < 0) first_rdy = cyc;
      if (din_ready && din_valid) xfer_cnt++;
      for (int r = 0; r < ROWS; r++) if (wl[r]) wl_cnt[r]++;

      e_busy = 0; e_done = 0; e_rdy = 0; e_cr = 0; e_row = '0; e_wl = '0; e_bl = '0;
      if (m_live) begin
        e_busy = 1;
        if (!m_cur) begin
          e_cr  = (cyc < m_e0 + CLRC);
          e_rdy = !e_cr;
        end else begin
          d    = cyc - m_t;
          e_bl = m_data;
          if (d >= S && d < S + P) e_wl = ROWS'(1) << m_row;
          if (d < S + P + H) e_row = 4'(m_row);
          else if (m_row < ROWS - 1) begin e_row = 4'(m_row + 1); e_rdy = 1; end
          else begin e_row = 4'(m_row); e_done = 1; end
        end
      end
      chk("outs", {busy, done, din_ready, cell_reset, row_idx, wl, bl},
                  {e_busy, e_done, e_rdy, e_cr, e_row, e_wl, e_bl});

      if (!RSTN || (m_live && abort)) begin
        m_live = 0; m_cur = 0;
      end else if (!m_live) begin
        if (start && !abort) begin
          m_live = 1; m_cur = 0; m_e0 = cyc + 1; start_cyc = cyc;
          done_cnt = 0; first_rdy = -1; cr_cnt = 0; xfer_cnt = 0;
          foreach (wl_cnt[r]) wl_cnt[r] = 0;
        end
      end else if (e_done) begin
        m_live = 0; m_cur = 0;
      end else if (e_rdy && din_valid) begin
        m_row  = m_cur ? m_row + 1 : 0;
        m_cur  = 1;
        m_t    = cyc + 1;
        m_data = din;
      end
    end
  end

  task automatic step();
    @(posedge prog_clk); #1;
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
  endtask

  // Streams ROWS rows; optional random gaps/data, a stall on one row, a start pulse during SETUP of one row.
  task automatic feed(input bit rnd, input int stall_row, input int stall_len, input int poke_row);
    int gaps, guard;
    bit ok;
    for (int r = 0; r < ROWS; r++) begin
      if (killed) break;
      gaps = rnd ? int'($urandom_range(0, 3)) : 0;
      if (r == stall_row) begin
        din_valid = 0; guard = 0;
        @(negedge prog_clk);
        while (!din_ready && guard < 100) begin @(negedge prog_clk); guard++; end
        for (int k = 0; k < stall_len; k++) begin
          if (k > 0) @(negedge prog_clk);
          chk("stall_wl", 32'(wl), 32'(0));
          chk("stall_rdy", 32'(din_ready), 32'(1));
        end
        step();
      end else if (gaps > 0) begin
        din_valid = 0;
        repeat (gaps) step();
      end
      din = rnd ? COLS'($urandom) : COLS'(r);
      din_valid = 1;
      ok = 0; guard = 0;
      while (!ok && !killed && guard < 200) begin
        @(negedge prog_clk); ok = din_ready; step(); guard++;
      end
      if (!ok && !killed) chk("xfer_rdy", 32'(din_ready), 32'(1));
      // Valid stays high into SETUP with different data; it must not be taken.
      din = COLS'($urandom);
      if (r == poke_row) begin start = 1; step(); start = 0; end
    end
    din_valid = 0;
  endtask

  // kind 1: abort in 2nd PULSE cycle of row; kind 2: RSTN low in the HOLD cycle of row.
  task automatic kill_at(input int kind, input int row);
    int guard;
    guard = 0;
    @(negedge prog_clk);
    while (wl !== (ROWS'(1) << row) && guard < 1000) begin @(negedge prog_clk); guard++; end
    chk("kill_wl_seen", 32'(wl), 32'(ROWS'(1) << row));
    if (kind == 1) begin
      step(); killed = 1; abort = 1; step(); abort = 0;
      @(negedge prog_clk);
      chk("abort_wl", 32'(wl), 32'(0));
      chk("abort_bl", 32'(bl), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_row", 32'(row_idx), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
    end else begin
      @(negedge prog_clk);
      step(); killed = 1; RSTN = 0; step(); RSTN = 1;
      @(negedge prog_clk);
      chk("rst_outs", {23'd0, bl, din_ready}, 32'(0));
      chk("rst_wl", 32'(wl), 32'(0));
      chk("rst_ctl", {28'd0, cell_reset, busy, done, 1'b0}, 32'(0));
      chk("rst_row", 32'(row_idx), 32'(0));
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge prog_clk);
    while (busy && guard < 400) begin @(negedge prog_clk); guard++; end
    chk("idle_busy", 32'(busy), 32'(0));
    step();
  endtask

  task automatic check_prog(input string tag, input bit timing);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
    chk({tag, "_rows"}, 32'(xfer_cnt), 32'(ROWS));
    chk({tag, "_clr_cyc"}, 32'(cr_cnt), 32'(CLRC));
    chk({tag, "_first_rdy"}, 32'(first_rdy - start_cyc), 32'(CLRC + 1));
    if (timing) begin
      chk({tag, "_done_lat"}, 32'(done_cyc - start_cyc), 32'(CLRC + ROWS * RP + 1));
      chk({tag, "_idle_lat"}, 32'(idle_cyc - (start_cyc + 1)), 32'(CLRC + ROWS * RP + 1));
      for (int r = 0; r < ROWS; r++) chk({tag, "_wl_len"}, 32'(wl_cnt[r]), 32'(P));
    end
  endtask

  initial begin
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    mon_en = 1;
    chk("rst_bl", 32'(bl), 32'(0));
    chk("rst_wl", 32'(wl), 32'(0));
    chk("rst_cell_reset", 32'(cell_reset), 32'(0));
    chk("rst_din_ready", 32'(din_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_row_idx", 32'(row_idx), 32'(0));
    step(); RSTN = 1; step();

    // abort and start together in IDLE: stays idle
    start = 1; abort = 1; step(); start = 0; abort = 0;
    @(negedge prog_clk);
    chk("abort_start_busy", 32'(busy), 32'(0));
    step();

    // full program, din = row index, valid held high
    do_start(); feed(0, -1, 0, -1); wait_idle(); check_prog("full", 1);

    // 7-cycle stall on row 3 with random data
    do_start(); feed(1, 3, 7, -1); wait_idle(); check_prog("stall", 0);

    // abort in 2nd PULSE cycle of row 5, then restart from row 0
    killed = 0; do_start();
    fork feed(0, -1, 0, -1); kill_at(1, 5); join
    repeat (4) step();
    chk("abort_no_done", 32'(done_cnt), 32'(0));
    killed = 0;
    do_start(); feed(1, -1, 0, -1); wait_idle(); check_prog("restart", 0);

    // RSTN pulse in HOLD of row 9, then a full program
    do_start();
    fork feed(0, -1, 0, -1); kill_at(2, 9); join
    step(); killed = 0;
    do_start(); feed(0, -1, 0, -1); wait_idle(); check_prog("after_rst", 1);

    // start pulsed during row 2 SETUP, valid held high through SETUP
    do_start(); feed(0, -1, 0, 2); wait_idle(); check_prog("poke", 1);
    repeat (3) step();
    @(negedge prog_clk);
    chk("poke_stays_idle", 32'(busy), 32'(0));
    chk("poke_single_done", 32'(done_cnt), 32'(1));
    step();

    // random-gap programs
    for (int i = 0; i < 2; i++) begin
      do_start(); feed(1, -1, 0, -1); wait_idle(); check_prog("rand", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
